// File: rtl/cfg_types_pkg.sv
// Shared types for the accelerator wrapper: sequencer state and error status encodings.
package cfg_types_pkg;

  localparam int unsigned LenWidth    = 6;
  localparam int unsigned OutCntWidth = 5;

  typedef enum logic [3:0] {
    StIdle    = 4'd0,
    StRdReq   = 4'd1,
    StRdWait  = 4'd2,
    StFeed    = 4'd3,
    StCollect = 4'd4,
    StWrite   = 4'd5,
    StDone    = 4'd6
  } acc_state_t;

  typedef enum logic [3:0] {
    ErrNone    = 4'd0,
    ErrLen     = 4'd1,
    ErrTimeout = 4'd2
  } acc_error_t;

endpackage

// File: rtl/accel_be_gen.sv
// Derives the result word count and the byte-enable mask of the final result word
// from the requested output length in bytes.
module accel_be_gen
  import cfg_types_pkg::*;
#(
  parameter int unsigned BeWidth = 4
) (
  input  logic [LenWidth-1:0]    len_i,
  output logic [OutCntWidth-1:0] n_words_o,
  output logic [BeWidth-1:0]     last_be_o
);

  logic [LenWidth:0] len_round;

  always_comb begin
    len_round = {1'b0, len_i} + (LenWidth + 1)'(3);
    n_words_o = OutCntWidth'(len_round >> 2);
    last_be_o = '1;
    // A length that is a multiple of four fills the whole final word.
    if (len_i[1:0] != 2'd0) begin
      last_be_o = BeWidth'((5'd1 << len_i[1:0]) - 5'd1);
    end
  end

endmodule

// File: rtl/accel_mem_sequencer.sv
// Job sequencer: streams IN_WORDS words from buffer SRAM into the core, writes results back.
// Optional core watchdog enabled by defining ACCEL_SEQ_TIMEOUT_EN.
module accel_mem_sequencer
  import cfg_types_pkg::*;
#(
  parameter int unsigned MEM_ADDR_WIDTH = 10,
  parameter int unsigned MEM_DATA_WIDTH = 32,
  parameter int unsigned MEM_DEPTH      = 1024,
  parameter int unsigned IN_WORDS       = 8,
  parameter int unsigned OUT_BASE       = 512,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [5:0]                  output_length_byte,
  output logic                        done,
  output logic [3:0]                  accel_state,
  output logic [3:0]                  accel_error,
  output logic                        mem_en,
  output logic                        mem_we,
  output logic [MEM_ADDR_WIDTH-1:0]   mem_addr,
  output logic [MEM_DATA_WIDTH/8-1:0] mem_be,
  output logic [MEM_DATA_WIDTH-1:0]   mem_wdata,
  input  logic [MEM_DATA_WIDTH-1:0]   mem_rdata,
  output logic                        core_in_valid,
  input  logic                        core_in_ready,
  output logic [MEM_DATA_WIDTH-1:0]   core_in_data,
  output logic                        core_in_last,
  input  logic                        core_out_valid,
  output logic                        core_out_ready,
  input  logic [MEM_DATA_WIDTH-1:0]   core_out_data
);

  localparam int unsigned BeWidth    = MEM_DATA_WIDTH / 8;
  localparam int unsigned RdCntWidth = $clog2(IN_WORDS) + 1;

  if (OUT_BASE + 16 > MEM_DEPTH) begin : g_depth_check
    $error("output region does not fit in the buffer");
  end

  acc_state_t                state_q, state_d;
  acc_error_t                error_q, error_d;
  logic [RdCntWidth-1:0]     rd_cnt_q, rd_cnt_d;
  logic [OutCntWidth-1:0]    wr_cnt_q, wr_cnt_d;
  logic [MEM_DATA_WIDTH-1:0] in_hold_q, in_hold_d;
  logic [MEM_DATA_WIDTH-1:0] out_hold_q, out_hold_d;
  logic [OutCntWidth-1:0]    n_words;
  logic [BeWidth-1:0]        last_be;
  logic                      rd_last, wr_last;

`ifdef ACCEL_SEQ_TIMEOUT_EN
  localparam int unsigned WdWidth = $clog2(TIMEOUT_CYCLES) + 1;
  logic [WdWidth-1:0] wdog_q, wdog_d;
`endif

  accel_be_gen #(
    .BeWidth (BeWidth)
  ) u_be_gen (
    .len_i     (output_length_byte),
    .n_words_o (n_words),
    .last_be_o (last_be)
  );

  assign accel_state = state_q;
  assign accel_error = error_q;
  assign rd_last     = (rd_cnt_q == RdCntWidth'(IN_WORDS - 1));
  assign wr_last     = (wr_cnt_q == n_words - OutCntWidth'(1));

  always_comb begin
    state_d        = state_q;
    error_d        = error_q;
    rd_cnt_d       = rd_cnt_q;
    wr_cnt_d       = wr_cnt_q;
    in_hold_d      = in_hold_q;
    out_hold_d     = out_hold_q;
    done           = 1'b0;
    mem_en         = 1'b0;
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_be         = '0;
    mem_wdata      = '0;
    core_in_valid  = 1'b0;
    core_in_data   = '0;
    core_in_last   = 1'b0;
    core_out_ready = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          error_d  = ErrNone;
          rd_cnt_d = '0;
          wr_cnt_d = '0;
          if (output_length_byte == '0) begin
            error_d = ErrLen;
            state_d = StDone;
          end else begin
            state_d = StRdReq;
          end
        end
      end
      StRdReq: begin
        mem_en   = 1'b1;
        mem_addr = MEM_ADDR_WIDTH'(rd_cnt_q);
        state_d  = StRdWait;
      end
      StRdWait: begin
        in_hold_d = mem_rdata;
        state_d   = StFeed;
      end
      StFeed: begin
        core_in_valid = 1'b1;
        core_in_data  = in_hold_q;
        core_in_last  = rd_last;
        if (core_in_ready) begin
          rd_cnt_d = rd_cnt_q + RdCntWidth'(1);
          state_d  = rd_last ? StCollect : StRdReq;
        end
      end
      StCollect: begin
        core_out_ready = 1'b1;
        if (core_out_valid) begin
          out_hold_d = core_out_data;
          state_d    = StWrite;
        end
      end
      StWrite: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = MEM_ADDR_WIDTH'(OUT_BASE) + MEM_ADDR_WIDTH'(wr_cnt_q);
        mem_wdata = out_hold_q;
        mem_be    = wr_last ? last_be : '1;
        wr_cnt_d  = wr_cnt_q + OutCntWidth'(1);
        state_d   = wr_last ? StDone : StCollect;
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

`ifdef ACCEL_SEQ_TIMEOUT_EN
    // Counts only consecutive stalled cycles; any handshake or state change restarts it.
    wdog_d = '0;
    if ((state_q == StFeed && !core_in_ready) || (state_q == StCollect && !core_out_valid)) begin
      wdog_d = wdog_q + WdWidth'(1);
      if (wdog_d == WdWidth'(TIMEOUT_CYCLES)) begin
        wdog_d  = '0;
        error_d = ErrTimeout;
        state_d = StDone;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      error_q    <= ErrNone;
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
      in_hold_q  <= '0;
      out_hold_q <= '0;
    end else begin
      state_q    <= state_d;
      error_q    <= error_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      in_hold_q  <= in_hold_d;
      out_hold_q <= out_hold_d;
    end
  end

`ifdef ACCEL_SEQ_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end
`endif

endmodule

// File: tb/tb_accel_mem_sequencer.sv
// Randomized bench for accel_mem_sequencer against a job-level reference model
// (expected reads, fed words, and written words/enables computed from the length).
module tb_accel_mem_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  output_length_byte = '0;
  logic        done;
  logic [3:0]  accel_state, accel_error;
  logic        mem_en, mem_we;
  logic [9:0]  mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        core_in_valid, core_in_last, core_out_ready;
  logic        core_in_ready = 1'b0;
  logic        core_out_valid = 1'b0;
  logic [31:0] core_in_data;
  logic [31:0] core_out_data = '0;

  accel_mem_sequencer #(
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .start              (start),
    .output_length_byte (output_length_byte),
    .done               (done),
    .accel_state        (accel_state),
    .accel_error        (accel_error),
    .mem_en             (mem_en),
    .mem_we             (mem_we),
    .mem_addr           (mem_addr),
    .mem_be             (mem_be),
    .mem_wdata          (mem_wdata),
    .mem_rdata          (mem_rdata),
    .core_in_valid      (core_in_valid),
    .core_in_ready      (core_in_ready),
    .core_in_data       (core_in_data),
    .core_in_last       (core_in_last),
    .core_out_valid     (core_out_valid),
    .core_out_ready     (core_out_ready),
    .core_out_data      (core_out_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Job-level model state
  logic [31:0] sram [8];
  logic [31:0] exp_out [16];
  int          exp_n, rd_idx, in_idx, out_acc, wr_idx, done_cnt, mem_cnt;
  logic [3:0]  exp_last_be, last_be_seen;
  bit          chk_en = 1'b0, stall_en = 1'b0, out_block = 1'b0, out_pend = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int model_n(input int len);
    return (len + 3) / 4;
  endfunction

  function automatic logic [3:0] model_last_be(input int len);
    int bytes;
    if (len == 0) return 4'hF;
    bytes = len - 4 * (model_n(len) - 1);
    return 4'((1 << bytes) - 1);
  endfunction

  // SRAM read port: data one cycle after a read request, garbage otherwise.
  always @(posedge clk) begin
    if (mem_en && !mem_we && mem_addr < 10'd8) mem_rdata <= sram[mem_addr[2:0]];
    else mem_rdata <= $urandom();
  end

  // Per-cycle compare against the model, then drive the core side for the next edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en && rst_n) begin
        if (mem_en) mem_cnt++;
        if (mem_en && !mem_we) begin
          check("rd_addr", 64'(mem_addr), 64'(rd_idx));
          rd_idx++;
        end
        if (mem_en && mem_we) begin
          check("wr_addr", 64'(mem_addr), 64'(512 + wr_idx));
          check("wr_data", 64'(mem_wdata), 64'(exp_out[wr_idx[3:0]]));
          check("wr_be", 64'(mem_be), 64'((wr_idx == exp_n - 1) ? exp_last_be : 4'hF));
          last_be_seen = mem_be;
          wr_idx++;
        end
        if (core_in_valid) begin
          check("in_data", 64'(core_in_data), 64'(sram[in_idx[2:0]]));
          check("in_last", 64'(core_in_last), 64'(in_idx == 7));
        end
        if (core_out_ready) check("out_ready_order", 64'(out_acc), 64'(wr_idx));
        if (done) done_cnt++;
      end
      core_in_ready = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (!out_pend) begin
        core_out_valid = out_block ? 1'b0 : (stall_en ? ($urandom_range(0, 2) != 0) : 1'b1);
        core_out_data  = (out_acc < 16) ? exp_out[out_acc[3:0]] : $urandom();
      end
      if (core_in_valid && core_in_ready) in_idx++;
      if (core_out_valid && core_out_ready) begin
        out_acc++;
        out_pend = 1'b0;
      end else begin
        out_pend = core_out_valid;
      end
    end
  end

  task automatic prep_job(input int len, input bit stall, input bit block);
    for (int i = 0; i < 8; i++) sram[i] = $urandom();
    for (int i = 0; i < 16; i++) exp_out[i] = $urandom();
    exp_n = model_n(len);
    exp_last_be = model_last_be(len);
    rd_idx = 0; in_idx = 0; out_acc = 0; wr_idx = 0; done_cnt = 0; mem_cnt = 0;
    out_pend = 1'b0; stall_en = stall; out_block = block;
    chk_en = 1'b1;
  endtask

  // Launch a job and return the number of cycles until done is seen (start held until then).
  task automatic run_job(input int len, input bit stall, input bit block, output int cyc,
                         output logic [3:0] err_at_done);
    prep_job(len, stall, block);
    @(negedge clk);
    output_length_byte = 6'(len);
    start = 1'b1;
    cyc = 0;
    err_at_done = 4'hx;
    do begin
      @(negedge clk);
      cyc++;
    end while (!done && cyc < 3000);
    check("job_done_seen", 64'(done), 64'd1);
    err_at_done = accel_error;
    start = 1'b0;
    @(negedge clk);
    check("state_back_idle", 64'(accel_state), 64'd0);
    @(negedge clk);
  endtask

  task automatic post_check(input int len);
    check("n_writes", 64'(wr_idx), 64'(model_n(len)));
    check("n_reads", 64'(rd_idx), 64'd8);
    check("n_fed", 64'(in_idx), 64'd8);
    check("done_pulses", 64'(done_cnt), 64'd1);
    check("error_none", 64'(accel_error), 64'd0);
  endtask

  initial begin
    int          cyc;
    logic [3:0]  err;
    int          len, k;

    // Pin the model to hand-computed values.
    check("model_n_5", 64'(model_n(5)), 64'd2);
    check("model_be_5", 64'(model_last_be(5)), 64'h1);
    check("model_n_63", 64'(model_n(63)), 64'd16);
    check("model_be_63", 64'(model_last_be(63)), 64'h7);
    check("model_be_32", 64'(model_last_be(32)), 64'hF);

    repeat (3) @(negedge clk);
    check("rst_outputs", 64'({done, accel_state, accel_error, mem_en, mem_we, mem_addr, mem_be,
                              core_in_valid, core_in_last, core_out_ready}), 64'd0);
    check("rst_wdata", 64'({mem_wdata, core_in_data}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_rst", 64'(accel_state), 64'd0);

    // Full job, no stalls: IDLE edge + 3 cycles per read word + 2 per write word.
    run_job(32, 1'b0, 1'b0, cyc, err);
    post_check(32);
    check("len32_cycles", 64'(cyc), 64'd41);
    check("len32_last_be", 64'(last_be_seen), 64'hF);

    run_job(5, 1'b0, 1'b0, cyc, err);
    post_check(5);
    check("len5_writes", 64'(wr_idx), 64'd2);
    check("len5_last_be", 64'(last_be_seen), 64'h1);

    run_job(63, 1'b0, 1'b0, cyc, err);
    post_check(63);
    check("len63_writes", 64'(wr_idx), 64'd16);
    check("len63_last_be", 64'(last_be_seen), 64'h7);

    // Zero length: DONE is entered on the start edge, so done shows in the next cycle.
    run_job(0, 1'b0, 1'b0, cyc, err);
    check("len0_no_mem", 64'(mem_cnt), 64'd0);
    check("len0_latency", 64'(cyc), 64'd1);
    check("len0_error", 64'(err), 64'd1);
    check("len0_error_sticky", 64'(accel_error), 64'd1);
    check("len0_done_pulses", 64'(done_cnt), 64'd1);

    // Random lengths with core stalls on both streams.
    for (int j = 0; j < 8; j++) begin
      len = $urandom_range(1, 63);
      run_job(len, 1'b1, 1'b0, cyc, err);
      post_check(len);
    end

    // Asynchronous reset while feeding the core.
    prep_job(32, 1'b1, 1'b0);
    @(negedge clk);
    output_length_byte = 6'd32;
    start = 1'b1;
    k = 0;
    while (accel_state != 4'd3 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("reach_feed", 64'(accel_state), 64'd3);
    #2;
    chk_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midjob_rst_outputs", 64'({done, accel_state, accel_error, mem_en, mem_we, mem_addr,
                                     mem_be, core_in_valid, core_in_last, core_out_ready}), 64'd0);
    check("midjob_rst_wdata", 64'({mem_wdata, core_in_data}), 64'd0);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_job(32, 1'b0, 1'b0, cyc, err);
    post_check(32);
    check("post_rst_cycles", 64'(cyc), 64'd41);

`ifdef ACCEL_SEQ_TIMEOUT_EN
    // Core never offers a result: 25 edges to reach COLLECT, then 16 stalled cycles.
    run_job(32, 1'b0, 1'b1, cyc, err);
    check("timeout_error", 64'(err), 64'd2);
    check("timeout_writes", 64'(wr_idx), 64'd0);
    check("timeout_cycles", 64'(cyc), 64'd41);
    check("timeout_done_pulses", 64'(done_cnt), 64'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
